// File: rtl/skipgram_train_ctrl_pkg.sv
// Shared types and fixed-point constants for the skip-gram training controller.
package skipgram_train_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StRdW  = 3'd1,
      StRdC  = 3'd2,
      StCapC = 3'd3,
      StEval = 3'd4,
      StWrW  = 3'd5,
      StWrC  = 3'd6,
      StDone = 3'd7
   } state_e;

   // Constants at the default FRAC of 8; use one_fx() for other settings.
   localparam int unsigned        FRAC_DEF = 8;
   localparam logic signed [15:0] ONE      = 16'sh0100;
   localparam logic signed [15:0] SAT_MAX  = 16'sh7FFF;
   localparam logic signed [15:0] SAT_MIN  = 16'sh8000;

   // 1.0 in signed 16-bit fixed point with the given number of fraction bits.
   function automatic logic signed [15:0] one_fx(input int unsigned frac);
      return 16'(32'd1 << frac);
   endfunction

endpackage

// File: rtl/skipgram_train_ctrl_emb_update.sv
// Applies one SGD step to a packed vector: old + ((err*grad) >>> (FRAC+LR_SHIFT)), saturated.
module emb_update
   import skipgram_train_ctrl_pkg::*;
#(
   parameter int unsigned DIM      = 3,
   parameter int unsigned FRAC     = 8,
   parameter int unsigned LR_SHIFT = 3
) (
   input  logic [16*DIM-1:0] vec_i,
   input  logic [16*DIM-1:0] grad_i,
   input  logic signed [15:0] err_i,
   output logic [16*DIM-1:0] vec_o
);

   localparam int unsigned SH = FRAC + LR_SHIFT;

   for (genvar i = 0; i < DIM; i++) begin : g_elem
      logic signed [15:0] old_e;
      logic signed [15:0] grad_e;
      logic signed [31:0] prod;
      logic signed [31:0] delta;
      logic signed [32:0] sum;

      assign old_e  = vec_i[16*i +: 16];
      assign grad_e = grad_i[16*i +: 16];
      assign prod   = err_i * grad_e;
      assign delta  = prod >>> SH;
      // One extra bit so the sum itself cannot wrap before saturation.
      assign sum    = 33'(old_e) + 33'(delta);

      // Clamp the widened sum back into signed 16-bit range.
      always_comb begin
         if (sum > 33'sd32767) begin
            vec_o[16*i +: 16] = SAT_MAX;
         end else if (sum < -33'sd32768) begin
            vec_o[16*i +: 16] = SAT_MIN;
         end else begin
            vec_o[16*i +: 16] = sum[15:0];
         end
      end
   end

endmodule

// File: rtl/skipgram_train_ctrl.sv
// Sequences one skip-gram training step: read both embeddings, evaluate, write both back.
module skipgram_train_ctrl
   import skipgram_train_ctrl_pkg::*;
#(
   parameter int unsigned DIM      = 3,
   parameter int unsigned VW       = 8,
   parameter int unsigned FRAC     = 8,
   parameter int unsigned LR_SHIFT = 3,
   parameter int unsigned DP_LAT   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [VW-1:0]       req_word_idx,
   input  logic [VW-1:0]       req_context_idx,
   input  logic                req_label,
   output logic [VW:0]         mem_addr,
   output logic                mem_rd_en,
   input  logic [16*DIM-1:0]   mem_rd_data,
   output logic                mem_wr_en,
   output logic [16*DIM-1:0]   mem_wr_data,
   output logic [16*DIM-1:0]   dp_word_embv,
   output logic [16*DIM-1:0]   dp_context_embv,
   input  logic [15:0]         dp_y,
   input  logic [16*DIM-1:0]   dp_dword,
   input  logic [16*DIM-1:0]   dp_dcontext,
   output logic                done_valid,
   input  logic                done_ready,
   output logic [15:0]         done_y,
   output logic                busy
);

   localparam int unsigned VB = 16 * DIM;

   state_e              state_q, state_d;
   logic [VW-1:0]       word_idx_q, word_idx_d;
   logic [VW-1:0]       ctx_idx_q, ctx_idx_d;
   logic                label_q, label_d;
   logic [VB-1:0]       word_vec_q, word_vec_d;
   logic [VB-1:0]       ctx_vec_q, ctx_vec_d;
   logic [VB-1:0]       dword_q, dword_d;
   logic [VB-1:0]       dctx_q, dctx_d;
   logic [15:0]         y_q, y_d;
   logic [15:0]         eval_cnt_q, eval_cnt_d;
   logic                eval_last;
   logic signed [15:0]  err;
   logic [VB-1:0]       word_upd;
   logic [VB-1:0]       ctx_upd;

   assign eval_last       = (eval_cnt_q == 16'(DP_LAT - 1));
   assign err             = (label_q ? one_fx(FRAC) : 16'sh0000) - $signed(y_q);
   assign dp_word_embv    = word_vec_q;
   assign dp_context_embv = ctx_vec_q;

   emb_update #(
      .DIM      (DIM),
      .FRAC     (FRAC),
      .LR_SHIFT (LR_SHIFT)
   ) u_word_upd (
      .vec_i  (word_vec_q),
      .grad_i (dword_q),
      .err_i  (err),
      .vec_o  (word_upd)
   );

   emb_update #(
      .DIM      (DIM),
      .FRAC     (FRAC),
      .LR_SHIFT (LR_SHIFT)
   ) u_ctx_upd (
      .vec_i  (ctx_vec_q),
      .grad_i (dctx_q),
      .err_i  (err),
      .vec_o  (ctx_upd)
   );

   // Next-state, register capture and decoded outputs for each step phase.
   always_comb begin
      state_d     = state_q;
      word_idx_d  = word_idx_q;
      ctx_idx_d   = ctx_idx_q;
      label_d     = label_q;
      word_vec_d  = word_vec_q;
      ctx_vec_d   = ctx_vec_q;
      dword_d     = dword_q;
      dctx_d      = dctx_q;
      y_d         = y_q;
      eval_cnt_d  = '0;
      req_ready   = 1'b0;
      busy        = 1'b1;
      mem_addr    = '0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      done_valid  = 1'b0;
      done_y      = '0;
      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               word_idx_d = req_word_idx;
               ctx_idx_d  = req_context_idx;
               label_d    = req_label;
               state_d    = StRdW;
            end
         end
         StRdW: begin
            mem_rd_en = 1'b1;
            mem_addr  = {1'b0, word_idx_q};
            state_d   = StRdC;
         end
         StRdC: begin
            word_vec_d = mem_rd_data;
            mem_rd_en  = 1'b1;
            mem_addr   = {1'b1, ctx_idx_q};
            state_d    = StCapC;
         end
         StCapC: begin
            ctx_vec_d = mem_rd_data;
            state_d   = StEval;
         end
         StEval: begin
            eval_cnt_d = eval_cnt_q + 16'd1;
            if (eval_last) begin
               // Snapshot the datapath so writes never see later dp_* changes.
               y_d        = dp_y;
               dword_d    = dp_dword;
               dctx_d     = dp_dcontext;
               eval_cnt_d = '0;
               state_d    = StWrW;
            end
         end
         StWrW: begin
            mem_wr_en   = 1'b1;
            mem_addr    = {1'b0, word_idx_q};
            mem_wr_data = word_upd;
            state_d     = StWrC;
         end
         StWrC: begin
            mem_wr_en   = 1'b1;
            mem_addr    = {1'b1, ctx_idx_q};
            mem_wr_data = ctx_upd;
            state_d     = StDone;
         end
         StDone: begin
            done_valid = 1'b1;
            done_y     = y_q;
            if (done_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and step registers; reset abandons any step in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         word_idx_q <= '0;
         ctx_idx_q  <= '0;
         label_q    <= 1'b0;
         word_vec_q <= '0;
         ctx_vec_q  <= '0;
         dword_q    <= '0;
         dctx_q     <= '0;
         y_q        <= '0;
         eval_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         ctx_idx_q  <= ctx_idx_d;
         label_q    <= label_d;
         word_vec_q <= word_vec_d;
         ctx_vec_q  <= ctx_vec_d;
         dword_q    <= dword_d;
         dctx_q     <= dctx_d;
         y_q        <= y_d;
         eval_cnt_q <= eval_cnt_d;
      end
   end

endmodule

// File: tb/tb_skipgram_train_ctrl.sv
// Scoreboard bench for skipgram_train_ctrl with a memory model and a timed datapath stub.
module tb_skipgram_train_ctrl;

   localparam int DIM = 3, VW = 8, FRAC = 8, LR_SHIFT = 3, DP_LAT = 1;

   typedef struct packed {
      logic [8:0]  addr;
      logic [47:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_label = 1'b0;
   logic [7:0]  req_word_idx = '0, req_context_idx = '0;
   logic [8:0]  mem_addr;
   logic        mem_rd_en, mem_wr_en;
   logic [47:0] mem_rd_data = '0, mem_wr_data;
   logic [47:0] dp_word_embv, dp_context_embv, dp_dword, dp_dcontext;
   logic [15:0] dp_y, done_y;
   logic        done_valid, done_ready = 1'b1, busy;

   logic [47:0] word_mem [256];
   logic [47:0] ctx_mem [256];
   logic [47:0] ref_word [256];
   logic [47:0] ref_ctx [256];
   wr_t         exp_wr_q[$];
   logic [15:0] exp_y_q[$];
   int          n_checks = 0, n_fail = 0, wr_cnt = 0;
   logic        stub_good = 1'b0;
   logic [15:0] stub_y = '0;
   logic        pl_en = 1'b0, pl_sel = 1'b0;
   logic [7:0]  pl_idx = '0;
   logic [47:0] pl_data = '0;

   always #5 clk = ~clk;

   // Stub outputs are only valid inside the EVAL window; elsewhere they are garbage.
   assign dp_y        = stub_good ? stub_y : ~stub_y;
   assign dp_dword    = stub_good ? dp_context_embv : ~dp_context_embv;
   assign dp_dcontext = stub_good ? dp_word_embv : ~dp_word_embv;

   skipgram_train_ctrl #(
      .DIM (DIM), .VW (VW), .FRAC (FRAC), .LR_SHIFT (LR_SHIFT), .DP_LAT (DP_LAT)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_word_idx    (req_word_idx),
      .req_context_idx (req_context_idx),
      .req_label       (req_label),
      .mem_addr        (mem_addr),
      .mem_rd_en       (mem_rd_en),
      .mem_rd_data     (mem_rd_data),
      .mem_wr_en       (mem_wr_en),
      .mem_wr_data     (mem_wr_data),
      .dp_word_embv    (dp_word_embv),
      .dp_context_embv (dp_context_embv),
      .dp_y            (dp_y),
      .dp_dword        (dp_dword),
      .dp_dcontext     (dp_dcontext),
      .done_valid      (done_valid),
      .done_ready      (done_ready),
      .done_y          (done_y),
      .busy            (busy)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference SGD update, written straight from the fixed-point definition.
   function automatic logic [47:0] upd(input logic [47:0] v, input logic [47:0] g,
                                       input logic signed [15:0] err);
      logic [47:0]        r;
      logic signed [15:0] o, gi;
      logic signed [31:0] p;
      int                 s;
      for (int i = 0; i < DIM; i++) begin
         o = v[16*i +: 16];
         gi = g[16*i +: 16];
         p = err * gi;
         s = int'(o) + int'(p >>> (FRAC + LR_SHIFT));
         if (s > 32767) r[16*i +: 16] = 16'h7FFF;
         else if (s < -32768) r[16*i +: 16] = 16'h8000;
         else r[16*i +: 16] = s[15:0];
      end
      return r;
   endfunction

   // Memory model: one-cycle read latency, writes on the strobe, plus a preload port.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem_addr[8] ? ctx_mem[mem_addr[7:0]] : word_mem[mem_addr[7:0]];
      if (mem_wr_en) begin
         if (mem_addr[8]) ctx_mem[mem_addr[7:0]] = mem_wr_data;
         else word_mem[mem_addr[7:0]] = mem_wr_data;
      end
      if (pl_en) begin
         if (pl_sel) ctx_mem[pl_idx] = pl_data;
         else word_mem[pl_idx] = pl_data;
      end
   end

   // Write and completion monitor popping the scoreboard.
   always @(negedge clk) begin
      if (mem_wr_en) begin
         wr_cnt++;
         check_eq("rd_during_wr", {63'd0, mem_rd_en}, 64'd0);
         if (exp_wr_q.size() == 0) begin
            check_eq("unexpected_wr", 64'd1, 64'd0);
         end else begin
            wr_t e;
            e = exp_wr_q.pop_front();
            check_eq("wr_addr", {55'd0, mem_addr}, {55'd0, e.addr});
            check_eq("wr_data", {16'd0, mem_wr_data}, {16'd0, e.data});
         end
      end
      if (done_valid && done_ready) begin
         if (exp_y_q.size() == 0) check_eq("unexpected_done", 64'd1, 64'd0);
         else check_eq("done_y", {48'd0, done_y}, {48'd0, exp_y_q.pop_front()});
      end
   end

   task automatic preload(input logic sel, input logic [7:0] idx, input logic [47:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_sel = sel; pl_idx = idx; pl_data = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
      if (sel) ref_ctx[idx] = d;
      else ref_word[idx] = d;
   endtask

   task automatic run_step(input logic [7:0] wi, input logic [7:0] ci, input logic lbl,
                           input logic [15:0] y, input bit hold);
      logic signed [15:0] err;
      logic [47:0]        w, c;
      logic [15:0]        y0;
      int                 n, edges;
      w = ref_word[wi];
      c = ref_ctx[ci];
      err = (lbl ? 16'sh0100 : 16'sh0000) - $signed(y);
      ref_word[wi] = upd(w, c, err);
      ref_ctx[ci] = upd(c, w, err);
      exp_wr_q.push_back('{addr: {1'b0, wi}, data: ref_word[wi]});
      exp_wr_q.push_back('{addr: {1'b1, ci}, data: ref_ctx[ci]});
      exp_y_q.push_back(y);
      @(negedge clk);
      req_word_idx = wi; req_context_idx = ci; req_label = lbl; req_valid = 1'b1;
      stub_y = y; done_ready = !hold;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("accept_ready", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 stub_good = 1'b1;
      repeat (DP_LAT) @(posedge clk);
      #1 stub_good = 1'b0;
      edges = 3 + DP_LAT;
      forever begin
         @(negedge clk);
         if (done_valid || edges >= 60) break;
         @(posedge clk);
         edges++;
      end
      if (!done_valid) begin
         check_eq("done_timeout", 64'd0, 64'd1);
         done_ready = 1'b1;
         return;
      end
      check_eq("latency", 64'(edges + 1), 64'(6 + DP_LAT));
      if (hold) begin
         y0 = done_y;
         for (int k = 0; k < 5; k++) begin
            check_eq("hold_valid", {63'd0, done_valid}, 64'd1);
            check_eq("hold_y", {48'd0, done_y}, {48'd0, y0});
            check_eq("hold_ready", {63'd0, req_ready}, 64'd0);
            @(posedge clk);
            #1 req_valid = 1'b1;
            @(negedge clk);
         end
         @(posedge clk);
         #1 done_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   initial begin
      #2;
      check_eq("rst_req_ready", {63'd0, req_ready}, 64'd1);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);
      check_eq("rst_rd_wr", {62'd0, mem_rd_en, mem_wr_en}, 64'd0);
      check_eq("rst_done", {47'd0, done_valid, done_y}, 64'd0);
      check_eq("rst_word_embv", {16'd0, dp_word_embv}, 64'd0);
      check_eq("rst_mem_out", {7'd0, mem_addr, mem_wr_data}, 64'd0);
      #20 rst_n = 1'b1;

      // Positive and negative steps from the documented setup.
      preload(1'b0, 8'd5, 48'h0000_0000_0100);
      preload(1'b1, 8'd9, 48'h0000_0000_0100);
      run_step(8'd5, 8'd9, 1'b1, 16'h0080, 1'b0);
      check_eq("pos_word5", {16'd0, word_mem[5]}, 64'h0110);
      check_eq("pos_ctx9", {16'd0, ctx_mem[9]}, 64'h0110);
      preload(1'b0, 8'd5, 48'h0000_0000_0100);
      preload(1'b1, 8'd9, 48'h0000_0000_0100);
      run_step(8'd5, 8'd9, 1'b0, 16'h0080, 1'b0);
      check_eq("neg_word5", {16'd0, word_mem[5]}, 64'h00F0);
      check_eq("neg_ctx9", {16'd0, ctx_mem[9]}, 64'h00F0);

      // Saturation at both ends (err = 0x0100).
      preload(1'b0, 8'd1, 48'h0000_8010_7FF0);
      preload(1'b1, 8'd2, 48'h0000_8000_7FFF);
      run_step(8'd1, 8'd2, 1'b1, 16'h0000, 1'b0);
      check_eq("sat_word_hi", {48'd0, word_mem[1][15:0]}, 64'h7FFF);
      check_eq("sat_word_lo", {48'd0, word_mem[1][31:16]}, 64'h8000);

      // Backpressure, then a second request that may only go in after the handshake.
      run_step(8'd5, 8'd9, 1'b1, 16'h0040, 1'b1);
      run_step(8'd9, 8'd5, 1'b0, 16'hFFC0, 1'b0);

      // Reset during EVAL abandons the step without a write.
      @(negedge clk);
      req_word_idx = 8'd5; req_context_idx = 8'd9; req_label = 1'b1; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_ready", {63'd0, req_ready}, 64'd1);
      check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
      check_eq("mid_rst_outs", {16'd0, dp_word_embv | dp_context_embv}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      begin
         int c0;
         c0 = wr_cnt;
         repeat (10) @(posedge clk);
         #1 check_eq("no_wr_after_rst", 64'(wr_cnt), 64'(c0));
      end

      // Ten back-to-back random steps over a small index range to force reuse.
      for (int i = 0; i < 8; i++) begin
         preload(1'b0, 8'(i), {16'($urandom), 16'($urandom), 16'($urandom)});
         preload(1'b1, 8'(i), {16'($urandom), 16'($urandom), 16'($urandom)});
      end
      for (int i = 0; i < 10; i++) begin
         run_step(8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 1'($urandom),
                  16'($urandom), 1'b0);
      end
      repeat (3) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         check_eq("final_word", {16'd0, word_mem[i]}, {16'd0, ref_word[i]});
         check_eq("final_ctx", {16'd0, ctx_mem[i]}, {16'd0, ref_ctx[i]});
      end
      check_eq("wr_q_drained", 64'(exp_wr_q.size()), 64'd0);
      check_eq("y_q_drained", 64'(exp_y_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/skipgram_train_ctrl.md
SKIPGRAM_TRAIN_CTRL -- requirements
Module: skipgram_train_ctrl

Interface
REQ-001 SHALL have parameters: DIM, default 3, embedding elements per vector; VW, default 8, vocabulary index width; FRAC, default 8, fraction bits of signed 16-bit fixed point; LR_SHIFT, default 3, learning-rate right shift; DP_LAT, default 1, datapath settle cycles.
REQ-002 SHALL have the following ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  training-pair request valid.
- req_ready  out  1  high only in IDLE.
- req_word_idx  in  VW  word index.
- req_context_idx  in  VW  context index.
- req_label  in  1  1 = positive sample, 0 = negative sample.
- mem_addr  out  VW+1  bit VW: 0 = word table, 1 = context table.
- mem_rd_en  out  1  read strobe; data returns on the next cycle.
- mem_rd_data  in  16*DIM  read data.
- mem_wr_en  out  1  write strobe.
- mem_wr_data  out  16*DIM  write data.
- dp_word_embv  out  16*DIM  registered datapath operand.
- dp_context_embv  out  16*DIM  registered datapath operand.
- dp_y  in  16  datapath prediction.
- dp_dword  in  16*DIM  word gradient.
- dp_dcontext  in  16*DIM  context gradient.
- done_valid  out  1  step complete.
- done_ready  in  1  consumer accepts.
- done_y  out  16  prediction for the completed step.
- busy  out  1  high when not in IDLE.
REQ-003 SHALL pack element i of every vector at bits [16*i+15 : 16*i].

Function
REQ-004 SHALL implement FSM IDLE -> RD_W -> RD_C -> CAP_C -> EVAL -> WR_W -> WR_C -> DONE -> IDLE.
REQ-005 IDLE: on req_valid&req_ready, latch indices and label; go to RD_W.
REQ-006 RD_W: mem_rd_en=1, mem_addr={0,word_idx}.
REQ-007 RD_C: capture mem_rd_data into dp_word_embv; mem_rd_en=1, mem_addr={1,context_idx}.
REQ-008 CAP_C: capture mem_rd_data into dp_context_embv.
REQ-009 EVAL: lasts DP_LAT cycles; on its last cycle register dp_y, dp_dword, dp_dcontext.
REQ-010 err = (label ? 1<<FRAC : 0) - y, as signed 16-bit.
REQ-011 Each updated element = old + ((err*grad_i) >>> (FRAC+LR_SHIFT)):
- 32-bit signed product, arithmetic shift.
- Result saturated to [0x8000, 0x7FFF].
REQ-012 WR_W: mem_wr_en=1, mem_addr={0,word_idx}, data = dp_word_embv updated with the registered dword.
REQ-013 WR_C: mem_wr_en=1, mem_addr={1,context_idx}, data = dp_context_embv updated with the registered dcontext.
REQ-014 Both updates SHALL use gradients captured in EVAL, never live dp_* values.
REQ-015 DONE: done_valid=1 and done_y=registered y, both held stable until done_ready; return to IDLE on the handshake cycle.
REQ-016 req_ready SHALL be 0 in every non-IDLE state; requests are not queued.
REQ-017 mem_rd_en and mem_wr_en SHALL never be high in the same cycle; each is high exactly one cycle per step.
REQ-018 word_idx equal to context_idx SHALL need no special handling (separate tables).
REQ-019 Step latency from the accept edge to the first done_valid cycle SHALL be 6+DP_LAT cycles.

Reset
REQ-020 rst_n low SHALL asynchronously force:
- state to IDLE.
- all outputs and registers to 0, except req_ready=1.
REQ-021 Reset mid-step SHALL abandon the step; no memory write is issued after rst_n deasserts until a new request is accepted.

Structure
REQ-022 A shared package SHALL hold:
- the FSM state enumeration.
- the fixed-point constants ONE=1<<FRAC, SAT_MAX=0x7FFF, SAT_MIN=0x8000.
REQ-023 Sub-module emb_update (one vector, gradient, err -> saturated updated vector) SHALL be instantiated twice.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Positive step:
  - Setup: word[5]={0x0100,0,0}, context[9]={0x0100,0,0}; datapath stub y=0x0080, dword=context, dcontext=word.
  - Stimulus: label=1.
  - Response: word[5] becomes {0x0110,0,0} and context[9] becomes {0x0110,0,0}; done_y=0x0080; latency 7.
- Negative step:
  - Setup: as the positive step.
  - Stimulus: label=0.
  - Response: err=0xFF80; both tables become {0x00F0,0,0}.
- Saturation: word element 0x7FF0, err=0x0100, grad=0x7FFF -> written 0x7FFF.
- Backpressure:
  - Stimulus: done_ready held low 5 cycles.
  - Response: done_valid and done_y stable; req_ready=0 throughout; second request accepted only after the handshake.
- Reset during EVAL -> no mem_wr_en pulse afterwards; req_ready=1; outputs 0.
- Ten back-to-back random requests vs reference model -> memory contents match bit-exactly.
